sprite_cmd_dispatcher: RTL and testbench

- Upstream stage feeding the sprite display blocks (block, pipe, player, etc.).
- Accepts 32-bit sprite command words from the HPS over an Avalon-MM slave and buffers them in a FIFO.
- Broadcasts them one per clock on the shared command bus; all display blocks sample that bus every cycle.
- Holds ping/pong flip commands until vertical blanking, so buffer swaps never tear a visible frame.

---
 rtl/sprite_cmd_dispatcher_pkg.sv | 38 +++
 rtl/sprite_cmd_dispatcher_if.sv | 21 ++
 rtl/sprite_cmd_dispatcher_cmd_fifo.sv | 56 +++++
 rtl/sprite_cmd_dispatcher.sv | 104 ++++++++++
 tb/tb_sprite_cmd_dispatcher.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_cmd_dispatcher_pkg.sv
// Shared types and codes for the sprite command path (command word layout, info/type codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_cmd_pkg;

  typedef struct packed {
    logic [5:0]  sub_comp;
    logic [4:0]  child_comp;
    logic [3:0]  info;
    logic [2:0]  input_type;
    logic        pp_selc;
    logic [12:0] input_msg;
  } cmd_word_t;

  localparam logic [3:0] INFO_NOP   = 4'h0;
  localparam logic [3:0] INFO_WRITE = 4'h1;
  localparam logic [3:0] INFO_FLIP  = 4'hF;

  localparam logic [2:0] TYPE_ATTR  = 3'b001;
  localparam logic [2:0] TYPE_X     = 3'b010;
  localparam logic [2:0] TYPE_Y     = 3'b011;
  localparam logic [2:0] TYPE_SHIFT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VBL
  } disp_state_t;

  function automatic logic [3:0] cmd_info(input cmd_word_t w);
    return w.info;
  endfunction

  function automatic logic cmd_pp_selc(input cmd_word_t w);
    return w.pp_selc;
  endfunction

endpackage

// File: rtl/sprite_cmd_dispatcher_if.sv
// Avalon-MM slave bundle between the HPS bridge and the sprite command dispatcher.
// Latency: n/a (wires only); readdata is combinational from the slave's registers.
// Backpressure: none; the slave never stalls, a full queue drops writes.
interface sprite_cmd_dispatcher_if;
  logic        avs_chipselect;
  logic        avs_write;
  logic        avs_read;
  logic        avs_address;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_chipselect, avs_write, avs_read, avs_address, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_chipselect, avs_write, avs_read, avs_address, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/sprite_cmd_dispatcher_cmd_fifo.sv
// Single-clock FIFO with a combinational head view, count, full and empty flags.
// Latency: a pushed word is visible at head one edge after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module cmd_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap modulo depth; count tracks occupancy independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_cmd_dispatcher.sv
// Buffers HPS sprite commands and broadcasts one per clock on cmd_data; flips wait for vertical blanking.
// Latency: push at edge E reaches cmd_data at edge E+1 when the queue was empty.
// Backpressure: none upstream; a write to a full queue is dropped and sets a sticky overflow bit.
module sprite_cmd_dispatcher
  import sprite_cmd_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          V_ACTIVE   = 480,
  parameter logic [3:0]  FLIP_INFO  = 4'hF,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  sprite_cmd_dispatcher_if.slave  avs,
  input  logic [9:0]              vcount,
  output logic [31:0]             cmd_data,
  output logic                    front_buf
);

  localparam int          AW            = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE       = (AW+1)'(1);
  localparam logic [9:0]  V_BLANK_START = 10'(V_ACTIVE);

  logic [31:0]  head_raw;
  logic [AW:0]  fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push_req;
  logic         status_rd;
  logic         pop;
  logic         overflow;
  logic         flip_done;
  logic         in_vblank;
  logic         head_flip;
  logic         flip_ok;
  disp_state_t  state;

  assign push_req  = avs.avs_chipselect & avs.avs_write & ~avs.avs_address;
  assign status_rd = avs.avs_chipselect & avs.avs_read & avs.avs_address;
  assign in_vblank = (vcount >= V_BLANK_START);
  assign head_flip = ~fifo_empty & (cmd_info(head_raw) == FLIP_INFO);
  assign flip_ok   = in_vblank & ~flip_done;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .push_dat (avs.avs_writedata),
    .pop      (pop),
    .head     (head_raw),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // IDLE acts on a freshly arrived head straight away so an empty queue still gives a 2-edge latency.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == ST_WAIT_VBL) pop = flip_ok;
      else                      pop = ~head_flip | flip_ok;
    end
  end

  // Dispatcher FSM: drives the command bus and front buffer; a held flip blocks everything behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_data  <= NOP_WORD;
      front_buf <= 1'b0;
      flip_done <= 1'b0;
    end else begin
      cmd_data <= NOP_WORD;
      if (!in_vblank) flip_done <= 1'b0;
      if (pop) begin
        cmd_data <= head_raw;
        if (head_flip) begin
          front_buf <= cmd_pp_selc(head_raw);
          flip_done <= 1'b1;
        end
        state <= (fifo_count == CNT_ONE) ? ST_IDLE : ST_ISSUE;
      end else if (!fifo_empty) begin
        // Only a flip outside an open blanking slot leaves a non-empty queue unpopped.
        state <= ST_WAIT_VBL;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a status read keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset)                              overflow <= 1'b0;
    else if (push_req & fifo_full & ~pop)   overflow <= 1'b1;
    else if (status_rd)                     overflow <= 1'b0;
  end

  // Only one readable register exists, so readdata needs no address decode.
  assign avs.avs_readdata = {20'd0, in_vblank, overflow, front_buf, head_flip, 2'b00, 6'(fifo_count)};

endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// Self-checking bench for sprite_cmd_dispatcher: table of per-cycle vectors plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_sprite_cmd_dispatcher;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] W0  = 32'h0822_4005;
  localparam logic [31:0] W1  = 32'h0822_8010;
  localparam logic [31:0] W2  = 32'h0822_C020;
  localparam logic [31:0] F1  = 32'h001E_2000;
  localparam logic [31:0] F0  = 32'h001E_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  vcount;
  logic [31:0] cmd_data;
  logic        front_buf;

  sprite_cmd_dispatcher_if bus();

  sprite_cmd_dispatcher #(
    .FIFO_DEPTH (16),
    .V_ACTIVE   (480),
    .FLIP_INFO  (4'hF),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .avs       (bus),
    .vcount    (vcount),
    .cmd_data  (cmd_data),
    .front_buf (front_buf)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;

  typedef struct {
    logic [9:0]  vc;
    bit          push;
    logic [31:0] wdata;
    logic [31:0] cmd;
    bit          fb;
    logic [5:0]  cnt;
    bit          hflip;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.avs_chipselect = 1'b0;
    bus.avs_write      = 1'b0;
    bus.avs_read       = 1'b0;
    bus.avs_address    = 1'b0;
    bus.avs_writedata  = 32'h0;
  endtask

  task automatic drive_push(input logic [31:0] w, input bit will_issue);
    bus.avs_chipselect = 1'b1;
    bus.avs_write      = 1'b1;
    bus.avs_read       = 1'b0;
    bus.avs_address    = 1'b0;
    bus.avs_writedata  = w;
    if (will_issue) exp_q.push_back(w);
  endtask

  function automatic void row(input logic [9:0] vc, input bit push, input logic [31:0] wdata,
                              input logic [31:0] cmd, input bit fb, input logic [5:0] cnt,
                              input bit hflip);
    vec_t v;
    v.vc = vc; v.push = push; v.wdata = wdata; v.cmd = cmd; v.fb = fb; v.cnt = cnt; v.hflip = hflip;
    tbl.push_back(v);
  endfunction

  // Scoreboard: every non-NOP bus word must be the oldest still-expected command.
  always @(negedge clk) begin
    if (mon_en && cmd_data !== NOP) begin
      if (exp_q.size() == 0) check("sb_unexpected", cmd_data, NOP);
      else                   check("sb_order", cmd_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    vcount = 10'd100;
    bus_idle();
    @(negedge clk);
    step();
    step();
    check("rst_cmd",  cmd_data, NOP);
    check("rst_fb",   32'(front_buf), 32'd0);
    check("rst_cnt",  32'(bus.avs_readdata[5:0]), 32'd0);
    check("rst_ovf",  32'(bus.avs_readdata[10]), 32'd0);
    check("rst_vbl",  32'(bus.avs_readdata[11]), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // idle
    for (int i = 0; i < 10; i++) row(10'd100, 1'b0, NOP, NOP, 1'b0, 6'd0, 1'b0);
    // three back-to-back writes
    row(10'd100, 1'b1, W0,  NOP, 1'b0, 6'd1, 1'b0);
    row(10'd100, 1'b1, W1,  W0,  1'b0, 6'd1, 1'b0);
    row(10'd100, 1'b1, W2,  W1,  1'b0, 6'd1, 1'b0);
    row(10'd100, 1'b0, NOP, W2,  1'b0, 6'd0, 1'b0);
    row(10'd100, 1'b0, NOP, NOP, 1'b0, 6'd0, 1'b0);
    // flip held until blanking, write behind it follows
    row(10'd100, 1'b1, F1,  NOP, 1'b0, 6'd1, 1'b1);
    row(10'd100, 1'b1, W0,  NOP, 1'b0, 6'd2, 1'b1);
    row(10'd100, 1'b0, NOP, NOP, 1'b0, 6'd2, 1'b1);
    row(10'd480, 1'b0, NOP, F1,  1'b1, 6'd1, 1'b0);
    row(10'd480, 1'b0, NOP, W0,  1'b1, 6'd0, 1'b0);
    row(10'd480, 1'b0, NOP, NOP, 1'b1, 6'd0, 1'b0);
    // two flips in one blanking interval
    row(10'd100, 1'b0, NOP, NOP, 1'b1, 6'd0, 1'b0);
    row(10'd490, 1'b1, F0,  NOP, 1'b1, 6'd1, 1'b1);
    row(10'd490, 1'b1, F1,  F0,  1'b0, 6'd1, 1'b1);
    row(10'd490, 1'b0, NOP, NOP, 1'b0, 6'd1, 1'b1);
    row(10'd490, 1'b0, NOP, NOP, 1'b0, 6'd1, 1'b1);
    row(10'd100, 1'b0, NOP, NOP, 1'b0, 6'd1, 1'b1);
    row(10'd480, 1'b0, NOP, F1,  1'b1, 6'd0, 1'b0);
    row(10'd480, 1'b0, NOP, NOP, 1'b1, 6'd0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      vcount = tbl[i].vc;
      if (tbl[i].push) drive_push(tbl[i].wdata, 1'b1);
      else             bus_idle();
      step();
      bus_idle();
      check($sformatf("v%0d_cmd", i),   cmd_data, tbl[i].cmd);
      check($sformatf("v%0d_fb", i),    32'(front_buf), 32'(tbl[i].fb));
      check($sformatf("v%0d_cnt", i),   32'(bus.avs_readdata[5:0]), 32'(tbl[i].cnt));
      check($sformatf("v%0d_hflip", i), 32'(bus.avs_readdata[8]), 32'(tbl[i].hflip));
    end
    check("vbl_status", 32'(bus.avs_readdata[11]), 32'd1);
    check("fb_status",  32'(bus.avs_readdata[9]),  32'd1);

    // overflow: waiting flip at head, fill to 16, 17th word is dropped
    vcount = 10'd100;
    step();
    drive_push(F1, 1'b1);
    step();
    for (int i = 0; i < 15; i++) begin
      drive_push(32'h0822_0000 + 32'(i + 1), 1'b1);
      step();
    end
    bus_idle();
    check("full_cnt",   32'(bus.avs_readdata[5:0]), 32'd16);
    check("full_ovf",   32'(bus.avs_readdata[10]), 32'd0);
    check("full_hflip", 32'(bus.avs_readdata[8]), 32'd1);
    check("full_cmd",   cmd_data, NOP);
    // a write to the status address must not enqueue or overflow
    bus.avs_chipselect = 1'b1; bus.avs_write = 1'b1; bus.avs_address = 1'b1; bus.avs_writedata = W0;
    step();
    bus_idle();
    check("addr1_wr_cnt", 32'(bus.avs_readdata[5:0]), 32'd16);
    check("addr1_wr_ovf", 32'(bus.avs_readdata[10]), 32'd0);
    drive_push(32'h0822_0FFF, 1'b0);
    step();
    bus_idle();
    check("ovf_set", 32'(bus.avs_readdata[10]), 32'd1);
    check("ovf_cnt", 32'(bus.avs_readdata[5:0]), 32'd16);
    bus.avs_chipselect = 1'b1; bus.avs_read = 1'b1; bus.avs_address = 1'b1;
    check("ovf_read", 32'(bus.avs_readdata[10]), 32'd1);
    step();
    bus_idle();
    check("ovf_clear", 32'(bus.avs_readdata[10]), 32'd0);

    // drain through blanking; scoreboard checks order
    vcount = 10'd480;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.avs_readdata[5:0] == 6'd0 && exp_q.size() == 0) break;
    end
    check("drain_cnt",   32'(bus.avs_readdata[5:0]), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_fb",    32'(front_buf), 32'd1);

    // reset while 5 commands wait behind a held flip
    vcount = 10'd100;
    step();
    drive_push(F0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive_push(W0, 1'b0);
      step();
    end
    bus_idle();
    step();
    check("pre_rst_cnt",   32'(bus.avs_readdata[5:0]), 32'd5);
    check("pre_rst_hflip", 32'(bus.avs_readdata[8]), 32'd1);
    check("pre_rst_fb",    32'(front_buf), 32'd1);
    check("pre_rst_cmd",   cmd_data, NOP);
    reset = 1'b1;
    step();
    check("mid_rst_cnt", 32'(bus.avs_readdata[5:0]), 32'd0);
    check("mid_rst_cmd", cmd_data, NOP);
    check("mid_rst_fb",  32'(front_buf), 32'd0);
    reset  = 1'b0;
    vcount = 10'd480;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_cnt", 32'(bus.avs_readdata[5:0]), 32'd0);
    check("post_rst_fb",  32'(front_buf), 32'd0);
    check("post_rst_cmd", cmd_data, NOP);
    check("final_queue",  32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
